// File: rtl/aes_seq_pkg.sv
// Shared constants and phase encoding for the byte-serial AES-128 round sequencer.
// Latencies are the defaults of the SubBytes / shiftrows / mixColumns pipelines.
package aes_seq_pkg;

  localparam int NBYTES  = 16;
  localparam int NROUNDS = 10;
  localparam int SB_LAT  = 1;
  localparam int SR_LAT  = 13;
  localparam int MC_LAT  = 4;
  localparam int CNT_W   = 6;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_KEY_WAIT   = 3'd1,
    PH_ARK        = 3'd2,
    PH_SUBBYTE    = 3'd3,
    PH_SHIFTROWS  = 3'd4,
    PH_MIXCOLUMNS = 3'd5
  } phase_e;

  function automatic logic [CNT_W-1:0] phase_lat(phase_e ph);
    logic [CNT_W-1:0] lat;
    lat = '0;
    case (ph)
      PH_SUBBYTE:    lat = CNT_W'(SB_LAT);
      PH_SHIFTROWS:  lat = CNT_W'(SR_LAT);
      PH_MIXCOLUMNS: lat = CNT_W'(MC_LAT);
      default:       lat = '0;
    endcase
    return lat;
  endfunction

  function automatic logic is_data_phase(phase_e ph);
    return (ph == PH_ARK) || (ph == PH_SUBBYTE) ||
           (ph == PH_SHIFTROWS) || (ph == PH_MIXCOLUMNS);
  endfunction

endpackage

// File: rtl/aes_round_sequencer_timer.sv
// Phase timer: counts 0..NBYTES+lat-1 while a data phase runs,
// derives the input-window and write-back strobes and the last-cycle flag.
module aes_phase_timer
  import aes_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] lat,
  output logic             dp_en,
  output logic             wb_en,
  output logic             last,
  output logic             col_start,
  output logic [3:0]       byte_idx
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len;

  assign len       = lat + CNT_W'(NBYTES);
  assign last      = run && (cnt_q == len - CNT_W'(1));
  assign dp_en     = run && (cnt_q < CNT_W'(NBYTES));
  assign wb_en     = run && (cnt_q >= lat) && (cnt_q < len);
  assign col_start = (cnt_q[1:0] == 2'd0);
  assign byte_idx  = dp_en ? cnt_q[3:0] : 4'd0;

  // A phase change always restarts the count from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (!last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encrypt round sequencer: phase FSM, round counter, key handshake.
// Optional AES_SEQ_ABORT_EN adds the abort input and aborted pulse output.
module aes_round_sequencer
  import aes_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] phase,
  output logic [3:0] round,
  output logic [3:0] byte_idx,
  output logic       dp_en,
  output logic       wb_en,
  output logic       en_sr,
  output logic [7:0] en_mc,
  output logic       rk_req,
  output logic [3:0] rk_round,
  input  logic       rk_ack
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  phase_e     phase_q;
  phase_e     phase_d;
  logic [3:0] round_q;
  logic [3:0] round_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;
  logic       rk_req_q;
  logic       rk_req_d;
  logic       abort_hit;
  logic       run;
  logic       clr;
  logic       last;
  logic       col_start;
  logic [CNT_W-1:0] lat;

`ifdef AES_SEQ_ABORT_EN
  logic aborted_q;
  logic aborted_d;
  assign abort_hit = abort && (phase_q != PH_IDLE);
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign run = is_data_phase(phase_q);
  assign lat = phase_lat(phase_q);
  assign clr = (phase_d != phase_q);

  aes_phase_timer u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .clr       (clr),
    .lat       (lat),
    .dp_en     (dp_en),
    .wb_en     (wb_en),
    .last      (last),
    .col_start (col_start),
    .byte_idx  (byte_idx)
  );

  always_comb begin
    phase_d  = phase_q;
    round_d  = round_q;
    rk_req_d = rk_req_q;
    done_d   = 1'b0;
    if (abort_hit) begin
      phase_d  = PH_IDLE;
      rk_req_d = 1'b0;
    end else begin
      unique case (phase_q)
        PH_IDLE: begin
          if (start) begin
            phase_d  = PH_KEY_WAIT;
            round_d  = 4'd0;
            rk_req_d = 1'b1;
          end
        end
        PH_KEY_WAIT: begin
          if (rk_ack) begin
            phase_d  = PH_ARK;
            rk_req_d = 1'b0;
          end
        end
        PH_ARK: begin
          if (last) begin
            if (round_q == 4'(NROUNDS)) begin
              phase_d = PH_IDLE;
              done_d  = 1'b1;
            end else begin
              phase_d = PH_SUBBYTE;
              round_d = round_q + 4'd1;
            end
          end
        end
        PH_SUBBYTE: begin
          if (last) begin
            phase_d = PH_SHIFTROWS;
          end
        end
        PH_SHIFTROWS: begin
          // The final round has no MixColumns step.
          if (last) begin
            if (round_q < 4'(NROUNDS)) begin
              phase_d = PH_MIXCOLUMNS;
            end else begin
              phase_d  = PH_KEY_WAIT;
              rk_req_d = 1'b1;
            end
          end
        end
        PH_MIXCOLUMNS: begin
          if (last) begin
            phase_d  = PH_KEY_WAIT;
            rk_req_d = 1'b1;
          end
        end
        default: begin
          phase_d  = PH_IDLE;
          rk_req_d = 1'b0;
        end
      endcase
    end
    busy_d = (phase_d != PH_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q   <= PH_IDLE;
      round_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rk_req_q  <= 1'b0;
`ifdef AES_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      phase_q   <= phase_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rk_req_q  <= rk_req_d;
`ifdef AES_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign phase    = phase_q;
  assign round    = round_q;
  assign rk_round = round_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_req   = rk_req_q;
  assign en_sr    = (phase_q == PH_SHIFTROWS);
  assign en_mc    = (phase_q == PH_MIXCOLUMNS && !col_start) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: phase-sequence scoreboard plus
// a per-cycle strobe model; abort steps run when AES_SEQ_ABORT_EN is defined.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_checks++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_aes_round_sequencer;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_KW   = 3'd1;
  localparam logic [2:0] P_ARK  = 3'd2;
  localparam logic [2:0] P_SB   = 3'd3;
  localparam logic [2:0] P_SR   = 3'd4;
  localparam logic [2:0] P_MC   = 3'd5;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] phase;
  logic [3:0] round;
  logic [3:0] byte_idx;
  logic       dp_en;
  logic       wb_en;
  logic       en_sr;
  logic [7:0] en_mc;
  logic       rk_req;
  logic [3:0] rk_round;
  logic       rk_ack = 1'b1;
`ifdef AES_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  typedef struct {
    logic [2:0] ph;
    int         dur;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic stall_en = 1'b0;
  int   stall_cnt = 0;
  int   mc10_bad = 0;

  always #5 clock = ~clock;

  aes_round_sequencer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .phase    (phase),
    .round    (round),
    .byte_idx (byte_idx),
    .dp_en    (dp_en),
    .wb_en    (wb_en),
    .en_sr    (en_sr),
    .en_mc    (en_mc),
    .rk_req   (rk_req),
    .rk_round (rk_round),
    .rk_ack   (rk_ack)
`ifdef AES_SEQ_ABORT_EN
    ,
    .abort    (abort),
    .aborted  (aborted)
`endif
  );

  function automatic logic [16:0] exp_vec(logic [2:0] ph, int p);
    int lat;
    logic data, dp, wb, sr, rq, bz;
    logic [7:0] mc;
    logic [3:0] bi;
    data = (ph >= P_ARK) && (ph <= P_MC);
    lat  = (ph == P_SB) ? 1 : (ph == P_SR) ? 13 : (ph == P_MC) ? 4 : 0;
    dp   = data && (p < 16);
    wb   = data && (p >= lat) && (p < lat + 16);
    sr   = (ph == P_SR);
    mc   = (ph == P_MC && (p % 4) != 0) ? 8'hFF : 8'h00;
    bi   = dp ? 4'(p) : 4'd0;
    rq   = (ph == P_KW);
    bz   = (ph != P_IDLE);
    return {dp, wb, sr, mc, bi, rq, bz};
  endfunction

  task automatic push_run(input int stall_round, input int extra);
    q.push_back('{P_KW, 1});
    q.push_back('{P_ARK, 16});
    for (int r = 1; r <= 10; r++) begin
      q.push_back('{P_SB, 17});
      q.push_back('{P_SR, 29});
      if (r < 10) q.push_back('{P_MC, 20});
      q.push_back('{P_KW, (r == stall_round) ? 1 + extra : 1});
      q.push_back('{P_ARK, 16});
    end
  endtask

  task automatic check_zero(input string tag);
    `CHK({tag, "_busy"}, busy, 1'b0)
    `CHK({tag, "_done"}, done, 1'b0)
    `CHK({tag, "_phase"}, phase, 3'd0)
    `CHK({tag, "_round"}, round, 4'd0)
    `CHK({tag, "_byte_idx"}, byte_idx, 4'd0)
    `CHK({tag, "_dp_en"}, dp_en, 1'b0)
    `CHK({tag, "_wb_en"}, wb_en, 1'b0)
    `CHK({tag, "_en_sr"}, en_sr, 1'b0)
    `CHK({tag, "_en_mc"}, en_mc, 8'h00)
    `CHK({tag, "_rk_req"}, rk_req, 1'b0)
    `CHK({tag, "_rk_round"}, rk_round, 4'd0)
`ifdef AES_SEQ_ABORT_EN
    `CHK({tag, "_aborted"}, aborted, 1'b0)
`endif
  endtask

  task automatic run_to_done(input int exp_lat, input int exp_busy, input string tag);
    int n;
    int b;
    n = 0;
    b = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (busy === 1'b1) b++;
    end while (done !== 1'b1 && n < 2000);
    `CHK({tag, "_done_latency"}, n, exp_lat)
    `CHK({tag, "_busy_cycles"}, b, exp_busy)
  endtask

  always @(negedge clock) begin
    if (stall_en && phase == P_KW && round == 4'd3 && stall_cnt < 5) begin
      rk_ack = 1'b0;
      stall_cnt++;
    end else begin
      rk_ack = 1'b1;
    end
  end

  logic [2:0] prev = 3'd0;
  int         pos = 0;
  int         wb_first = -1;
  int         wb_cnt = 0;
  int         exp_round = 0;

  always @(negedge clock) begin
    if (!mon_en) begin
      prev = phase;
      pos  = 0;
    end else begin
      if (phase !== prev) begin
        if (prev != P_IDLE) begin
          n_checks++;
          assert (q.size() > 0) else begin
            n_fail++;
            $error("FAIL seq_extra observed=%0h expected=none", prev);
          end
          if (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            `CHK("phase_seq", prev, e.ph)
            `CHK("phase_len", pos + 1, e.dur)
          end
          if (prev == P_SR) begin
            `CHK("sr_wb_first", wb_first, 13)
            `CHK("sr_wb_len", wb_cnt, 16)
          end
        end
        if (prev == P_ARK && phase == P_SB) exp_round++;
        if (prev == P_IDLE && phase == P_KW) exp_round = 0;
        prev     = phase;
        pos      = 0;
        wb_first = -1;
        wb_cnt   = 0;
      end else begin
        pos++;
      end
      `CHK("strobes", {dp_en, wb_en, en_sr, en_mc, byte_idx, rk_req, busy},
           exp_vec(phase, pos))
      if (phase != P_IDLE) begin
        `CHK("round", round, 4'(exp_round))
        `CHK("rk_round", rk_round, 4'(exp_round))
      end
      if (wb_en === 1'b1) begin
        if (wb_cnt == 0) wb_first = pos;
        wb_cnt++;
      end
      if (round == 4'd10 && phase != P_IDLE && en_mc != 8'h00) mc10_bad++;
    end
  end

  initial begin
    int guard;
    int done_seen;
    reset_n = 1'b0;
    start   = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;

    // Full block with the key always ready.
    push_run(0, 0);
    start = 1'b1;
    run_to_done(828, 827, "t1");
    `CHK("t1_round10_no_mc", mc10_bad, 0)

    // Back-to-back start on the done cycle, key stalled in round 3.
    #1;
    `CHK("t1_queue_empty", q.size(), 0)
    stall_en  = 1'b1;
    stall_cnt = 0;
    push_run(3, 5);
    start = 1'b1;
    run_to_done(833, 832, "t2");
    stall_en = 1'b0;
    `CHK("t2_stall_cycles", stall_cnt, 5)
    @(negedge clock);
    `CHK("t2_done_pulse", done, 1'b0)
    `CHK("t2_queue_empty", q.size(), 0)

    // Start while busy is ignored, then reset in round 5.
    repeat (2) @(negedge clock);
    push_run(0, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(round == 4'd2 && phase == P_SB) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    `CHK("t5_reach_r2", round, 4'd2)
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(round == 4'd5 && phase == P_SR) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    `CHK("t5_reach_r5", phase, P_SR)
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check_zero("mid_reset");
    reset_n = 1'b1;
    q.delete();
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) done_seen++;
    end
    `CHK("t5_no_done", done_seen, 0)
    `CHK("t5_idle", phase, P_IDLE)

`ifdef AES_SEQ_ABORT_EN
    mon_en = 1'b1;
    @(negedge clock);
    push_run(0, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(round == 4'd2 && phase == P_SR) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    `CHK("t6_reach_r2", phase, P_SR)
    mon_en = 1'b0;
    abort  = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    `CHK("t6_aborted", aborted, 1'b1)
    `CHK("t6_phase", phase, P_IDLE)
    `CHK("t6_busy", busy, 1'b0)
    `CHK("t6_done", done, 1'b0)
    `CHK("t6_rk_req", rk_req, 1'b0)
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    `CHK("t6_aborted_once", aborted, 1'b0)
    `CHK("t6_done_after", done, 1'b0)
    q.delete();
    mon_en = 1'b1;
    @(negedge clock);
    push_run(0, 0);
    start = 1'b1;
    run_to_done(828, 827, "t6");
    #1;
    `CHK("t6_queue_empty", q.size(), 0)
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
